// File: rtl/median_pkg.sv
// Shared types for the median filter family: pixel type, row-buffer occupancy
// and a width helper for counters that must stay at least one bit wide.
package median_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   // Counter width for n states; never collapses to zero bits when n == 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/median_row_buffer.sv
// Two-entry row store with per-entry row tags. Written one whole row at a time,
// read one pixel at a time through the selected entry and column.
module median_row_buffer
   import median_pkg::*;
#(
   parameter int W     = 98,
   parameter int TAG_W = 7,
   parameter int COL_W = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic             wsel,
   input  pixel_t           row_in [W-1:0],
   input  logic [TAG_W-1:0] tag_in,
   input  logic             rsel,
   input  logic [COL_W-1:0] col,
   output pixel_t           pix,
   output logic [TAG_W-1:0] tag
);

   pixel_t           mem_r [2][W];
   logic [TAG_W-1:0] tag_r [2];

   // Capture an accepted row and its tag; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < W; i++) begin
            mem_r[wsel][i] <= row_in[i];
         end
         tag_r[wsel] <= tag_in;
      end
   end

   assign pix = mem_r[rsel][col];
   assign tag = tag_r[rsel];

endmodule

// File: rtl/median_row_serializer.sv
// Buffers row-parallel median filter output in two slots and streams it one
// pixel per cycle over valid/ready with line and frame markers.
module median_row_serializer
   import median_pkg::*;
#(
   parameter int SIZE = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       row_valid,
   input  logic       frame_start,
   input  logic [7:0] row_in [SIZE-3:0],
   output logic [7:0] pix_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       pix_sol,
   output logic       pix_eol,
   output logic       pix_sof,
   output logic       pix_eof,
   output logic       overflow,
   output logic       busy
);

   localparam int W     = SIZE - 2;
   localparam int ROWS  = SIZE - 2;
   localparam int COL_W = clog2_min1(W);
   localparam int TAG_W = clog2_min1(ROWS);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
   localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ROWS - 1);

   occ_e             state_r;
   logic             wsel_r;
   logic             rsel_r;
   logic [COL_W-1:0] col_r;
   logic [TAG_W-1:0] in_row_r;
   logic             overflow_r;

   logic             valid_s;
   logic             hs_s;
   logic             release_s;
   logic             accept_s;
   logic             drop_s;
   logic [TAG_W-1:0] tag_s;
   logic [TAG_W-1:0] next_row_s;
   pixel_t           buf_pix_s;
   logic [TAG_W-1:0] buf_tag_s;

   median_row_buffer #(
      .W     (W),
      .TAG_W (TAG_W),
      .COL_W (COL_W)
   ) u_buf (
      .clk    (clk),
      .we     (accept_s),
      .wsel   (wsel_r),
      .row_in (row_in),
      .tag_in (tag_s),
      .rsel   (rsel_r),
      .col    (col_r),
      .pix    (buf_pix_s),
      .tag    (buf_tag_s)
   );

   // Handshake, release and accept decisions; a release frees a FULL slot in the same cycle.
   always_comb begin
      valid_s   = (state_r != EMPTY);
      hs_s      = valid_s && pix_ready;
      release_s = hs_s && (col_r == LAST_COL);
      accept_s  = row_valid && ((state_r != FULL) || release_s);
      drop_s    = row_valid && !accept_s;
      if (frame_start) begin
         tag_s = {TAG_W{1'b0}};
      end else begin
         tag_s = in_row_r;
      end
      if (tag_s == LAST_TAG) begin
         next_row_s = {TAG_W{1'b0}};
      end else begin
         next_row_s = tag_s + TAG_W'(1);
      end
   end

   // Occupancy FSM with pointers, column counter, input row counter and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= EMPTY;
         wsel_r     <= 1'b0;
         rsel_r     <= 1'b0;
         col_r      <= {COL_W{1'b0}};
         in_row_r   <= {TAG_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (accept_s) begin
            wsel_r <= ~wsel_r;
         end
         // Dropped rows still count so the frame tagging stays aligned.
         if (row_valid) begin
            in_row_r <= next_row_s;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         if (hs_s) begin
            if (release_s) begin
               col_r  <= {COL_W{1'b0}};
               rsel_r <= ~rsel_r;
            end else begin
               col_r <= col_r + COL_W'(1);
            end
         end
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_r <= ONE;
               end
            end
            ONE: begin
               if (accept_s && !release_s) begin
                  state_r <= FULL;
               end else if (release_s && !accept_s) begin
                  state_r <= EMPTY;
               end
            end
            FULL: begin
               if (release_s && !accept_s) begin
                  state_r <= ONE;
               end
            end
            default: begin
               state_r <= EMPTY;
            end
         endcase
      end
   end

   // Output data and markers, all forced low while nothing is buffered.
   always_comb begin
      if (valid_s) begin
         pix_data = buf_pix_s;
         pix_sol  = (col_r == {COL_W{1'b0}});
         pix_eol  = (col_r == LAST_COL);
         pix_sof  = (col_r == {COL_W{1'b0}}) && (buf_tag_s == {TAG_W{1'b0}});
         pix_eof  = (col_r == LAST_COL) && (buf_tag_s == LAST_TAG);
      end else begin
         pix_data = 8'd0;
         pix_sol  = 1'b0;
         pix_eol  = 1'b0;
         pix_sof  = 1'b0;
         pix_eof  = 1'b0;
      end
   end

   assign pix_valid = valid_s;
   assign busy      = valid_s;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_median_row_serializer.sv
// Directed bench for median_row_serializer (SIZE=6): queue-based row model
// compared every cycle, plus literal expectations on the captured pixel stream.
module tb_median_row_serializer;

   localparam int SIZE = 6;
   localparam int W    = 4;
   localparam int ROWS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       row_valid;
   logic       frame_start;
   logic [7:0] row_in [SIZE-3:0];
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic       pix_sol, pix_eol, pix_sof, pix_eof;
   logic       overflow;
   logic       busy;

   always #5 clk = ~clk;

   median_row_serializer #(.SIZE(SIZE)) dut (
      .clk         (clk),
      .rst         (rst),
      .row_valid   (row_valid),
      .frame_start (frame_start),
      .row_in      (row_in),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_sol     (pix_sol),
      .pix_eol     (pix_eol),
      .pix_sof     (pix_sof),
      .pix_eof     (pix_eof),
      .overflow    (overflow),
      .busy        (busy)
   );

   typedef struct packed {
      logic [W-1:0][7:0] pix;
      logic [1:0]        tag;
   } row_t;

   typedef struct packed {
      logic [7:0] d;
      logic       sol;
      logic       eol;
      logic       sof;
      logic       eof;
   } px_t;

   row_t mq[$];
   int   m_col    = 0;
   int   m_in_row = 0;
   bit   m_ovf    = 1'b0;
   px_t  got[$];

   int checks   = 0;
   int failures = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of at most two rows and a read column.
   initial begin
      bit   hs, rel;
      int   tag;
      row_t r;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            m_col    = 0;
            m_in_row = 0;
            m_ovf    = 1'b0;
         end else begin
            hs  = (mq.size() > 0) && (pix_ready === 1'b1);
            rel = hs && (m_col == W - 1);
            if (hs) begin
               if (rel) begin
                  mq.delete(0);
                  m_col = 0;
               end else begin
                  m_col++;
               end
            end
            if (row_valid) begin
               tag      = frame_start ? 0 : m_in_row;
               m_in_row = (tag + 1) % ROWS;
               if (mq.size() < 2) begin
                  for (int c = 0; c < W; c++) r.pix[c] = row_in[c];
                  r.tag = 2'(tag);
                  mq.push_back(r);
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
      end
   end

   // Compare process: mid-cycle check of every output against the model.
   initial begin
      bit         ev, esol, eeol;
      logic [7:0] ed;
      int         etag;
      forever begin
         @(negedge clk);
         if (checking) begin
            ev   = (mq.size() > 0);
            ed   = ev ? mq[0].pix[m_col] : 8'd0;
            etag = ev ? int'(mq[0].tag) : -1;
            esol = ev && (m_col == 0);
            eeol = ev && (m_col == W - 1);
            chk("pix_valid", {31'd0, pix_valid}, {31'd0, ev});
            chk("pix_data",  {24'd0, pix_data},  {24'd0, ed});
            chk("pix_sol",   {31'd0, pix_sol},   {31'd0, esol});
            chk("pix_eol",   {31'd0, pix_eol},   {31'd0, eeol});
            chk("pix_sof",   {31'd0, pix_sof},   {31'd0, esol && (etag == 0)});
            chk("pix_eof",   {31'd0, pix_eof},   {31'd0, eeol && (etag == ROWS - 1)});
            chk("busy",      {31'd0, busy},      {31'd0, ev});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            if (pix_valid && pix_ready && !rst) begin
               got.push_back('{d: pix_data, sol: pix_sol, eol: pix_eol, sof: pix_sof, eof: pix_eof});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      row_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic set_row(input logic [7:0] a, b, c, d, input logic fs);
      row_in[0]   = a;
      row_in[1]   = b;
      row_in[2]   = c;
      row_in[3]   = d;
      row_valid   = 1'b1;
      frame_start = fs;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      got.delete();
   endtask

   initial begin
      int         sent;
      int         cyc;
      logic [7:0] exp1 [4];

      rst         = 1'b1;
      row_valid   = 1'b0;
      frame_start = 1'b0;
      pix_ready   = 1'b0;
      for (int i = 0; i < W; i++) row_in[i] = 8'd0;
      step();
      step();
      checking = 1'b1;
      rst      = 1'b0;
      chk("reset_valid",    {31'd0, pix_valid}, 32'd0);
      chk("reset_data",     {24'd0, pix_data},  32'd0);
      chk("reset_busy",     {31'd0, busy},      32'd0);
      chk("reset_overflow", {31'd0, overflow},  32'd0);

      // Single row with continuous ready.
      do_reset();
      exp1 = '{8'd10, 8'd20, 8'd30, 8'd40};
      pix_ready = 1'b1;
      set_row(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
      step();
      repeat (4) step();
      chk("single_count", got.size(), 32'd4);
      if (got.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("single_data", {24'd0, got[i].d},   {24'd0, exp1[i]});
            chk("single_sol",  {31'd0, got[i].sol}, (i == 0) ? 32'd1 : 32'd0);
            chk("single_sof",  {31'd0, got[i].sof}, (i == 0) ? 32'd1 : 32'd0);
            chk("single_eol",  {31'd0, got[i].eol}, (i == 3) ? 32'd1 : 32'd0);
            chk("single_eof",  {31'd0, got[i].eof}, 32'd0);
         end
      end
      chk("single_busy_after", {31'd0, busy}, 32'd0);

      // Full frame, ready alternating, rows offered whenever a slot is free.
      do_reset();
      sent = 0;
      cyc  = 0;
      while (got.size() < 16 && cyc < 200) begin
         pix_ready = (cyc % 2 == 0);
         if (sent < 4 && mq.size() < 2) begin
            set_row(8'(16*sent+1), 8'(16*sent+2), 8'(16*sent+3), 8'(16*sent+4), sent == 0);
            sent++;
         end
         step();
         cyc++;
      end
      chk("frame_count", got.size(), 32'd16);
      if (got.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("frame_data", {24'd0, got[i].d},   32'(16*(i/4) + (i%4) + 1));
            chk("frame_sol",  {31'd0, got[i].sol}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk("frame_eol",  {31'd0, got[i].eol}, (i % 4 == 3) ? 32'd1 : 32'd0);
            chk("frame_sof",  {31'd0, got[i].sof}, (i == 0)  ? 32'd1 : 32'd0);
            chk("frame_eof",  {31'd0, got[i].eof}, (i == 15) ? 32'd1 : 32'd0);
         end
      end
      chk("frame_overflow", {31'd0, overflow}, 32'd0);

      // Overflow: third row on consecutive cycles is dropped.
      do_reset();
      pix_ready = 1'b0;
      set_row(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
      step();
      set_row(8'd5, 8'd6, 8'd7, 8'd8, 1'b0);
      step();
      set_row(8'd9, 8'd10, 8'd11, 8'd12, 1'b0);
      step();
      step();
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      pix_ready = 1'b1;
      repeat (8) step();
      chk("ovf_drain_count", got.size(), 32'd8);
      if (got.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("ovf_data", {24'd0, got[i].d}, 32'(i + 1));
      end
      set_row(8'd13, 8'd14, 8'd15, 8'd16, 1'b0);
      step();
      repeat (4) step();
      chk("ovf_next_count", got.size(), 32'd12);
      if (got.size() == 12) begin
         chk("ovf_next_data", {24'd0, got[8].d},    32'd13);
         chk("ovf_next_sof",  {31'd0, got[8].sof},  32'd0);
         chk("ovf_next_eof",  {31'd0, got[11].eof}, 32'd1);
      end
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Release of the last pixel coincides with a new row while FULL.
      do_reset();
      pix_ready = 1'b0;
      set_row(8'd100, 8'd101, 8'd102, 8'd103, 1'b1);
      step();
      set_row(8'd110, 8'd111, 8'd112, 8'd113, 1'b0);
      step();
      pix_ready = 1'b1;
      repeat (3) step();
      set_row(8'd120, 8'd121, 8'd122, 8'd123, 1'b0);
      step();
      chk("simul_busy",     {31'd0, busy},     32'd1);
      chk("simul_overflow", {31'd0, overflow}, 32'd0);
      repeat (8) step();
      chk("simul_count", got.size(), 32'd12);
      if (got.size() == 12) begin
         for (int i = 0; i < 12; i++) chk("simul_data", {24'd0, got[i].d}, 32'(100 + 10*(i/4) + (i%4)));
      end
      chk("simul_overflow_end", {31'd0, overflow}, 32'd0);

      // Reset after two pixels of a row.
      do_reset();
      pix_ready = 1'b1;
      set_row(8'd50, 8'd51, 8'd52, 8'd53, 1'b1);
      step();
      step();
      step();
      chk("mid_pre_count", got.size(), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_valid", {31'd0, pix_valid}, 32'd0);
      chk("mid_data",  {24'd0, pix_data},  32'd0);
      chk("mid_busy",  {31'd0, busy},      32'd0);
      chk("mid_sof",   {31'd0, pix_sof},   32'd0);
      step();
      chk("mid_valid_next", {31'd0, pix_valid}, 32'd0);
      got.delete();
      set_row(8'd60, 8'd61, 8'd62, 8'd63, 1'b0);
      step();
      repeat (4) step();
      chk("mid_fresh_count", got.size(), 32'd4);
      if (got.size() == 4) begin
         chk("mid_fresh_data", {24'd0, got[0].d},   32'd60);
         chk("mid_fresh_sof",  {31'd0, got[0].sof}, 32'd1);
         chk("mid_fresh_last", {24'd0, got[3].d},   32'd63);
      end

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
